muldiv_unit: RTL

- Iterative multiply/divide unit with HI/LO result registers for the single-cycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU alongside the ALU, one result bit per cycle.
- Uses a shift-add multiplier and a restoring divider.
- Downstream consumer of the adder datapath results; feeds mfhi/mflo.
- The core stalls on busy_o.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings, FSM states and the iteration counter width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One result bit per cycle: shift-add multiply, restoring divide.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start_i         request, taken in IDLE or DONE
//   op_i, a_i, b_i  operation and operands, sampled with start_i
//   busy_o          high in RUN and FIXUP
//   done_o          one-cycle pulse, HI/LO valid
//   div_by_zero_o   divide with b=0, only while done_o
//   hi_o, lo_o      HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  muldiv_op_t       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] mag_q;
  logic             res_neg_q;
  logic             rem_neg_q;
  logic             dbz_q;

  logic             accept;
  logic             is_mul;
  logic             in_signed;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_x, add_y, sum;
  logic             add_cin;
  logic [WIDTH:0]   upper;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  assign accept = start_i &&
    (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = RUN;
      RUN:   if (cnt_q == '0) state_d = FIXUP;
      FIXUP: state_d = DONE;
      DONE:  state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RUN) ||
    (state_q == FIXUP);
  assign done_o = (state_q == DONE);
  assign div_by_zero_o = done_o && dbz_q;

  // Operand magnitudes for the signed ops.
  assign in_signed = (op_i == OP_MULT) ||
    (op_i == OP_DIV);
  assign sa = in_signed && a_i[WIDTH-1];
  assign sb = in_signed && b_i[WIDTH-1];
  assign abs_a = sa ? -a_i : a_i;
  assign abs_b = sb ? -b_i : b_i;

  // One shared adder: add for multiply,
  // subtract (x + ~y + 1) for the divide trial.
  assign is_mul = (op_q == OP_MULT) ||
    (op_q == OP_MULTU);
  assign add_x = is_mul
    ? {1'b0, acc_q[W2-1:WIDTH]}
    : acc_q[W2-1:WIDTH-1];
  assign add_y = is_mul ? {1'b0, mag_q}
                        : ~{1'b0, mag_q};
  assign add_cin = !is_mul;
  assign sum = add_x + add_y +
    {{WIDTH{1'b0}}, add_cin};

  assign upper = acc_q[0] ? sum
    : {1'b0, acc_q[W2-1:WIDTH]};

  assign prod = res_neg_q ? -acc_q : acc_q;
  assign quo = acc_q[WIDTH-1:0];
  // With a zero divisor every trial succeeds,
  // so rem ends as |a|; the remainder sign
  // fix then restores the raw dividend.
  assign rem = rem_neg_q ? -acc_q[W2-1:WIDTH]
                         : acc_q[W2-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else if (accept) begin
      op_q      <= muldiv_op_t'(op_i);
      cnt_q     <= CNT_W'(WIDTH - 1);
      res_neg_q <= sa ^ sb;
      rem_neg_q <= sa;
      dbz_q     <= op_i[1] && (b_i == '0);
      if (!op_i[1]) begin
        mag_q <= abs_a;
        acc_q <= {{WIDTH{1'b0}}, abs_b};
      end else begin
        mag_q <= abs_b;
        acc_q <= {{WIDTH{1'b0}}, abs_a};
      end
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - 1'b1;
      if (is_mul)
        acc_q <= {upper, acc_q[WIDTH-1:1]};
      else if (!sum[WIDTH])
        acc_q <= {sum[WIDTH-1:0],
                  acc_q[WIDTH-2:0], 1'b1};
      else
        acc_q <= {acc_q[W2-2:0], 1'b0};
    end else if (state_q == FIXUP) begin
      if (is_mul) begin
        hi_o <= prod[W2-1:WIDTH];
        lo_o <= prod[WIDTH-1:0];
      end else begin
        hi_o <= rem;
        if (dbz_q)          lo_o <= '1;
        else if (res_neg_q) lo_o <= -quo;
        else                lo_o <= quo;
      end
    end
  end

endmodule
